// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART receiver:
//   - rx_state_e : receiver FSM state encoding
//   - PARITY_*   : values accepted by the PARITY parameter
//   - log2c()    : ceiling log2 used to size counters and pointers
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int log2c(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
// Receive-side stream of the UART receiver.
//   data_out   : received word, valid while data_valid=1
//   data_valid : word available
//   data_ready : consumer accepts on data_valid & data_ready at posedge clk
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   parity_err : 1-cycle pulse, parity mismatch
//   overrun    : 1-cycle pulse, good frame dropped for lack of storage
//   busy       : receiver FSM not idle
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data_out, data_valid, frame_err, parity_err, overrun, busy,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, parity_err, overrun, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead FIFO holding received words. dout presents the head entry while
// the FIFO is non-empty and reads 0 when empty.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and word (ignored when full unless popping)
//   pop        : remove head entry (ignored when empty)
//   dout       : head entry
//   full/empty : occupancy status
// A push while full succeeds when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = log2c(FIFO_DEPTH);

    logic [AW-1:0]        wr_q, wr_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                 do_push, do_pop;

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; empty gates dout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver with its own bit-timing divider, configurable data
// width and parity, and a valid/ready output stream with error reporting.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   uart_rx : serial line, idle high, asynchronous to clk
//   rx_if   : uart_rx_param_if.master (data_out/data_valid/data_ready,
//             frame_err, parity_err, overrun, busy)
// Build option UART_RX_FIFO_EN:
//   defined   -> received words go through a FIFO_DEPTH-entry show-ahead FIFO
//   undefined -> single holding register, FIFO_DEPTH unused
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 20,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            uart_rx,
    uart_rx_param_if.master rx_if
);
    localparam int                DIV_W    = log2c(CLK_DIV);
    localparam int                CNT_W    = log2c(DATA_BITS);
    localparam logic [DIV_W-1:0]  DIV_FULL = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic              PAR_ODD  = (PARITY == PARITY_ODD);

    rx_state_e            state_q, state_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q;
    logic                 tick, fall, push, pop, store_full;

    assign tick = (div_q == '0);
    assign fall = rx_prev_q & ~rx_s2_q;
    assign pop  = rx_if.data_valid & rx_if.data_ready;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;

        // The divider free-runs through a frame; every zero is a mid-bit sample.
        if (state_q != ST_IDLE && state_q != ST_BREAK) begin
            div_d = tick ? DIV_FULL : div_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                    div_d   = DIV_HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_bad_d = rx_s2_q ^ (^shift_q) ^ PAR_ODD;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // Errors are reported together here so both pulses can coincide.
                if (tick) begin
                    parity_err_d = par_bad_q;
                    if (rx_s2_q) begin
                        push    = ~par_bad_q;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A pop in the same cycle frees a slot before the push lands.
        overrun_d = push & store_full & ~pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            bit_cnt_q    <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            div_q        <= div_d;
            bit_cnt_q    <= bit_cnt_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.overrun    = overrun_q;
    assign rx_if.busy       = busy_q;

`ifdef UART_RX_FIFO_EN
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push & (~fifo_full | pop)),
        .din   (shift_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign store_full       = fifo_full;
    assign rx_if.data_valid = ~fifo_empty;
    assign rx_if.data_out   = fifo_dout;
`else
    logic                 hold_vld_q, hold_vld_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_load;

    always_comb begin
        hold_load  = push & (~hold_vld_q | pop);
        hold_vld_d = hold_vld_q;
        if (pop) begin
            hold_vld_d = 1'b0;
        end
        if (hold_load) begin
            hold_vld_d = 1'b1;
        end
        hold_d = hold_load ? shift_q : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign store_full       = hold_vld_q;
    assign rx_if.data_valid = hold_vld_q;
    assign rx_if.data_out   = hold_vld_q ? hold_q : '0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Three receivers (PARITY none / even / odd) on separate serial lines. Frames
// are built bit by bit from the UART frame rules; the expected beats and flag
// pulses are queued when a frame is issued and a monitor process pops and
// compares them as the receivers present outputs.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CD = 20;
    localparam int DB = 8;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0] id;
        logic       fe;
        logic       pe;
        logic       ov;
    } flag_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] line;
    logic [2:0] rdy;
    logic [2:0] dv, fe, pe, ov, bsy;
    logic [7:0] dout [3];

    beat_t data_q[$];
    flag_t flag_q[$];
    int    pushed [3];
    int    popped [3];
    int    vec_cnt  = 0;
    int    miss_cnt = 0;
    int    busy_chk = 0;
    int    chk_dut  = 0;
    bit    final_req  = 1'b0;
    bit    final_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        uart_rx_param_if #(.DATA_BITS(DB)) ifc ();

        uart_rx_param #(
            .CLK_DIV    (CD),
            .DATA_BITS  (DB),
            .PARITY     (g),
            .FIFO_DEPTH (4)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .uart_rx (line[g]),
            .rx_if   (ifc)
        );

        assign ifc.data_ready = rdy[g];
        assign dv[g]   = ifc.data_valid;
        assign fe[g]   = ifc.frame_err;
        assign pe[g]   = ifc.parity_err;
        assign ov[g]   = ifc.overrun;
        assign bsy[g]  = ifc.busy;
        assign dout[g] = ifc.data_out;
    end

    task automatic bit_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one frame on line g. abort_bit >= 0 resets the design in the middle
    // of that data bit; hold_low keeps the line low after a bad stop bit.
    task automatic send_frame(input int g, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input int abort_bit, input int hold_low);
        logic  pbit;
        bit    perr;
        beat_t b;
        flag_t f;
        perr = (g != 0) && bad_par;
        pbit = (g == 2) ? ~(^d) : (^d);
        if (perr) pbit = ~pbit;
        if (abort_bit < 0) begin
            f.id = 2'(g);
            f.fe = bad_stop;
            f.pe = perr;
            f.ov = 1'b0;
            if (bad_stop || perr) begin
                flag_q.push_back(f);
            end else if (pushed[g] - popped[g] < CAP) begin
                b.id   = 2'(g);
                b.data = d;
                data_q.push_back(b);
                pushed[g]++;
            end else begin
                f.ov = 1'b1;
                flag_q.push_back(f);
            end
        end
        line[g] = 1'b0;
        bit_wait(CD);
        for (int i = 0; i < DB; i++) begin
            line[g] = d[i];
            if (i == abort_bit) begin
                bit_wait(CD / 2);
                rst_n = 1'b0;
                bit_wait(4);
                line[g] = 1'b1;
                bit_wait(1);
                rst_n = 1'b1;
                bit_wait(CD);
                return;
            end
            bit_wait(CD);
        end
        if (g != 0) begin
            line[g] = pbit;
            bit_wait(CD);
        end
        line[g] = ~bad_stop;
        bit_wait(CD);
        if (bad_stop) begin
            if (hold_low > 0) begin
                chk_dut  = g;
                busy_chk = 1;
                bit_wait(hold_low);
                busy_chk = 0;
            end
            line[g] = 1'b1;
            bit_wait(4);
        end
    endtask

    task automatic glitch(input int g, input int n);
        line[g] = 1'b0;
        bit_wait(n);
        line[g] = 1'b1;
        bit_wait(2 * CD);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (data_q.size() != 0 || flag_q.size() != 0); i++) begin
            bit_wait(1);
        end
        bit_wait(CD);
    endtask

    task automatic idle_check(input int g);
        chk_dut  = g;
        busy_chk = 2;
        bit_wait(5);
        busy_chk = 0;
    endtask

    // Monitor: all comparisons happen here.
    always @(negedge clk) begin
        beat_t be, bg;
        flag_t fexp, fgot;
        if (!rst_n) begin
            for (int g = 0; g < 3; g++) begin
                vec_cnt++;
                if ({dv[g], fe[g], pe[g], ov[g], bsy[g]} != 5'b0 || dout[g] != 8'h00) begin
                    miss_cnt++;
                    $display("FAIL reset_outputs dut%0d: valid=%b fe=%b pe=%b ov=%b busy=%b data=%h, required all 0",
                             g, dv[g], fe[g], pe[g], ov[g], bsy[g], dout[g]);
                end
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (fe[g] | pe[g] | ov[g]) begin
                    vec_cnt++;
                    fgot.id = 2'(g);
                    fgot.fe = fe[g];
                    fgot.pe = pe[g];
                    fgot.ov = ov[g];
                    if (flag_q.size() == 0) begin
                        miss_cnt++;
                        $display("FAIL flag_spurious dut%0d: fe=%b pe=%b ov=%b, required no pulse",
                                 g, fe[g], pe[g], ov[g]);
                    end else begin
                        fexp = flag_q.pop_front();
                        if (fgot != fexp) begin
                            miss_cnt++;
                            $display("FAIL flag_pulse dut%0d: got id=%0d fe=%b pe=%b ov=%b, required id=%0d fe=%b pe=%b ov=%b",
                                     g, fgot.id, fgot.fe, fgot.pe, fgot.ov, fexp.id, fexp.fe, fexp.pe, fexp.ov);
                        end
                    end
                end
                if (dv[g]) begin
                    bg.id   = 2'(g);
                    bg.data = dout[g];
                    if (data_q.size() == 0) begin
                        vec_cnt++;
                        miss_cnt++;
                        $display("FAIL data_spurious dut%0d: data=%h, required no valid", g, dout[g]);
                    end else begin
                        be = data_q[0];
                        if (rdy[g]) begin
                            vec_cnt++;
                            void'(data_q.pop_front());
                            popped[g]++;
                            if (bg != be) begin
                                miss_cnt++;
                                $display("FAIL data_beat dut%0d: got id=%0d data=%h, required id=%0d data=%h",
                                         g, bg.id, bg.data, be.id, be.data);
                            end
                        end else if (be.id == 2'(g)) begin
                            vec_cnt++;
                            if (bg != be) begin
                                miss_cnt++;
                                $display("FAIL data_hold dut%0d: got data=%h, required data=%h",
                                         g, bg.data, be.data);
                            end
                        end
                    end
                end
            end
            if (busy_chk != 0) begin
                vec_cnt++;
                if (bsy[chk_dut] != (busy_chk == 1)) begin
                    miss_cnt++;
                    $display("FAIL busy dut%0d: got %b, required %b", chk_dut, bsy[chk_dut], busy_chk == 1);
                end
            end
            if (final_req && !final_done) begin
                vec_cnt++;
                if (data_q.size() != 0 || flag_q.size() != 0) begin
                    miss_cnt++;
                    $display("FAIL leftover_expectations: got %0d beats %0d flags outstanding, required 0 and 0",
                             data_q.size(), flag_q.size());
                end
                final_done = 1'b1;
            end
        end
    end

    initial begin
        line = 3'b111;
        rdy  = 3'b111;
        for (int g = 0; g < 3; g++) begin
            pushed[g] = 0;
            popped[g] = 0;
        end
        #2 rst_n = 1'b0;
        bit_wait(5);
        rst_n = 1'b1;
        bit_wait(5);
        idle_check(0);

        // Back-to-back frames, no parity.
        send_frame(0, 8'h55, 1'b0, 1'b0, -1, 0);
        send_frame(0, 8'hA3, 1'b0, 1'b0, -1, 0);
        drain();

        // Wrong then right parity, even and odd receivers.
        send_frame(1, 8'h07, 1'b1, 1'b0, -1, 0);
        send_frame(1, 8'h07, 1'b0, 1'b0, -1, 0);
        drain();
        send_frame(2, 8'h07, 1'b1, 1'b0, -1, 0);
        send_frame(2, 8'h07, 1'b0, 1'b0, -1, 0);
        drain();

        // Bad stop bit with the line held low, then a normal frame.
        send_frame(0, 8'h3C, 1'b0, 1'b1, -1, 100);
        send_frame(0, 8'h81, 1'b0, 1'b0, -1, 0);
        drain();
        idle_check(0);

        // Short low glitch on an idle line.
        glitch(0, 4);
        drain();
        idle_check(0);

        // Consumer stalled while frames keep arriving.
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b0, -1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b0, -1, 0);
        send_frame(0, 8'h33, 1'b0, 1'b0, -1, 0);
`ifdef UART_RX_FIFO_EN
        send_frame(0, 8'h44, 1'b0, 1'b0, -1, 0);
        send_frame(0, 8'h55, 1'b0, 1'b0, -1, 0);
`endif
        bit_wait(CD);
        rdy[0] = 1'b1;
        drain();

        // Reset in the middle of data bit 4, then a clean frame.
        send_frame(0, 8'hF0, 1'b0, 1'b0, 4, 0);
        send_frame(0, 8'h0F, 1'b0, 1'b0, -1, 0);
        drain();

        // Randomised bursts on one receiver at a time.
        for (int b = 0; b < 25; b++) begin
            int g;
            int n;
            g = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 5));
            rdy[g] = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    glitch(g, int'($urandom_range(1, 8)));
                end
                send_frame(g, 8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                           -1, int'($urandom_range(0, 40)));
                bit_wait(int'($urandom_range(0, 30)));
            end
            rdy[g] = 1'b1;
            drain();
        end

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) begin
            bit_wait(1);
        end
        if (!final_done) begin
            $display("FAIL final_check: got no end-of-run check, required one");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
